// File: rtl/ar_mux41_tdm_if.sv
// Lane bundle for the 4:1 TDM serializer: per-channel input handshake plus
// the registered (a, sel, enable) output lane with its ready backpressure.
interface ar_mux41_tdm_if #(
  parameter int W = 1
);
  logic           en;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_ready;
  logic [W-1:0]   a;
  logic [1:0]     sel;
  logic           enable;

  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, a, sel, enable
  );

  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, a, sel, enable
  );
endinterface

// File: rtl/ar_mux41_tdm.sv
// Time-division 4:1 multiplexer: four one-entry channel buffers drained by a
// round-robin arbiter onto a single registered, backpressurable lane.
module ar_mux41_tdm #(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst,
  ar_mux41_tdm_if.slave    bus_io
);
  logic [3:0]   buf_full_q, buf_full_d;
  logic [W-1:0] buf_data_q [4];
  logic [W-1:0] buf_data_d [4];
  logic [1:0]   ptr_q, ptr_d;
  logic [W-1:0] a_q, a_d;
  logic [1:0]   sel_q, sel_d;
  logic         enable_q, enable_d;

  logic         load;
  logic [1:0]   grant;
  logic [1:0]   cand;

  assign load = bus_io.en && (|buf_full_q) && (!enable_q || bus_io.out_ready);

  // Scan from the farthest offset back to ptr so the closest full buffer wins.
  always_comb begin
    grant = ptr_q;
    cand  = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (buf_full_q[cand]) grant = cand;
    end
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    sel_d      = sel_q;
    enable_d   = enable_q;

    for (int i = 0; i < 4; i++) begin
      if (bus_io.in_valid[i] && !buf_full_q[i]) begin
        buf_full_d[i] = 1'b1;
        buf_data_d[i] = bus_io.in_data[i*W +: W];
      end
    end

    // A granted buffer was full, so it cannot also be accepting this edge.
    if (load) begin
      buf_full_d[grant] = 1'b0;
      a_d               = buf_data_q[grant];
      sel_d             = grant;
      enable_d          = 1'b1;
      ptr_d             = grant + 2'd1;
    end else if (enable_q && bus_io.out_ready) begin
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_q <= '0;
      for (int i = 0; i < 4; i++) buf_data_q[i] <= '0;
      ptr_q      <= '0;
      a_q        <= '0;
      sel_q      <= '0;
      enable_q   <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      sel_q      <= sel_d;
      enable_q   <= enable_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign bus_io.in_ready[gi] = ~buf_full_q[gi];
  end

  assign bus_io.a      = a_q;
  assign bus_io.sel    = sel_q;
  assign bus_io.enable = enable_q;
endmodule

// File: tb/tb_ar_mux41_tdm.sv
// Bench for ar_mux41_tdm: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural lane model.
module tb_ar_mux41_tdm;
  localparam int W = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ar_mux41_tdm_if #(.W(W)) bus_if ();

  ar_mux41_tdm #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buffers as arrays, lane as three plain variables.
  logic         m_full [4];
  logic [W-1:0] m_data [4];
  int           m_ptr;
  logic [W-1:0] m_a;
  int           m_sel;
  logic         m_enable;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = '0;
      end
      m_ptr = 0; m_a = '0; m_sel = 0; m_enable = 1'b0;
    end else begin
      int  g;
      bit  ld;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (g < 0 && m_full[c]) g = c;
      end
      ld = bus_if.en && (g >= 0) && (!m_enable || bus_if.out_ready);
      for (int i = 0; i < 4; i++) begin
        if (bus_if.in_valid[i] && !m_full[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = bus_if.in_data[i*W +: W];
        end
      end
      if (ld) begin
        m_a       = m_data[g];
        m_sel     = g;
        m_enable  = 1'b1;
        m_full[g] = 1'b0;
        m_ptr     = (g + 1) % 4;
      end else if (m_enable && bus_if.out_ready) begin
        m_enable = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) exp_rdy[i] = ~m_full[i];
      chk("model_enable", bus_if.enable, m_enable);
      chk("model_sel", bus_if.sel, m_sel);
      chk("model_a", bus_if.a, m_a);
      chk("model_in_ready", bus_if.in_ready, exp_rdy);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_a", bus_if.a, 0);
    chk("rst_sel", bus_if.sel, 0);
    chk("rst_enable", bus_if.enable, 0);
    chk("rst_in_ready", bus_if.in_ready, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lane(input string nm, input logic e, input logic [1:0] s, input logic [W-1:0] d);
    chk({nm, "_enable"}, bus_if.enable, e);
    if (e) begin
      chk({nm, "_sel"}, bus_if.sel, s);
      chk({nm, "_a"}, bus_if.a, d);
    end
  endtask

  initial begin
    logic [3:0] av;
    bus_if.en        = 1'b1;
    bus_if.in_valid  = '0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("init_enable", bus_if.enable, 0);
    chk("init_in_ready", bus_if.in_ready, 4'b1111);
    cmp_on = 1'b1;
    do_reset();

    // Single channel: one word every other cycle.
    bus_if.in_valid = 4'b0010;
    bus_if.in_data  = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("single_rdy1", bus_if.in_ready[1], c % 2);
      lane("single", 1'(c % 2), 2'd1, 1'b1);
    end
    bus_if.in_valid = '0;
    step();
    chk("single_drain", bus_if.enable, 0);

    // All four buffers filled at once, then drained in order.
    do_reset();
    av = 4'b1101;
    bus_if.in_valid = 4'b1111;
    bus_if.in_data  = av;
    step();
    chk("fill_in_ready", bus_if.in_ready, 4'b0000);
    chk("fill_enable", bus_if.enable, 0);
    bus_if.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      lane("rr", 1'b1, 2'(k), av[k]);
    end
    step();
    chk("rr_drain", bus_if.enable, 0);

    // Pointer wrap: last grant was channel 2, then channels 0 and 3 pending.
    do_reset();
    bus_if.in_valid = 4'b0100;
    bus_if.in_data  = 4'b0100;
    step();
    bus_if.in_valid = 4'b1001;
    bus_if.in_data  = 4'b0001;
    step();
    lane("wrap_first", 1'b1, 2'd2, 1'b1);
    bus_if.in_valid = '0;
    step();
    lane("wrap_ch3", 1'b1, 2'd3, 1'b0);
    step();
    lane("wrap_ch0", 1'b1, 2'd0, 1'b1);
    step();
    chk("wrap_drain", bus_if.enable, 0);

    // Backpressure while channel 1 sits on the lane.
    do_reset();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 4'b1111;
    bus_if.in_data   = 4'b1101;
    step();
    bus_if.in_valid  = '0;
    bus_if.out_ready = 1'b1;
    step();
    lane("bp_ch0", 1'b1, 2'd0, 1'b1);
    step();
    lane("bp_ch1", 1'b1, 2'd1, 1'b0);
    bus_if.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      lane("bp_hold", 1'b1, 2'd1, 1'b0);
      chk("bp_in_ready", bus_if.in_ready, 4'b0011);
    end
    bus_if.out_ready = 1'b1;
    step();
    lane("bp_ch2", 1'b1, 2'd2, 1'b1);
    step();
    lane("bp_ch3", 1'b1, 2'd3, 1'b1);
    step();
    chk("bp_drain", bus_if.enable, 0);

    // Arbitration disabled with two buffers full.
    do_reset();
    bus_if.en       = 1'b0;
    bus_if.in_valid = 4'b0011;
    bus_if.in_data  = 4'b0010;
    step();
    bus_if.in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("en0_enable", bus_if.enable, 0);
      chk("en0_in_ready", bus_if.in_ready, 4'b1100);
    end
    bus_if.en = 1'b1;
    step();
    lane("en1_ch0", 1'b1, 2'd0, 1'b0);
    step();
    lane("en1_ch1", 1'b1, 2'd1, 1'b1);
    step();
    chk("en1_drain", bus_if.enable, 0);

    // Reset with a word on the lane and buffers full.
    bus_if.in_valid = 4'b1111;
    bus_if.in_data  = 4'b1111;
    step();
    bus_if.in_valid = '0;
    step();
    chk("pre_rst_enable", bus_if.enable, 1);
    do_reset();
    step();
    chk("post_rst_enable", bus_if.enable, 0);
    chk("post_rst_in_ready", bus_if.in_ready, 4'b1111);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        bus_if.en        = ($urandom_range(0, 7) != 0);
        bus_if.in_valid  = 4'($urandom);
        bus_if.in_data   = (4*W)'($urandom);
        bus_if.out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ar_mux41_tdm.md
# ar_mux41_tdm

Time-division 4:1 multiplexer and serializer. It is the transmit end of the path whose receive end is the `ar_demux14` 1:4 demultiplexer. Four independent input channels each get a one-entry holding buffer, and a round-robin arbiter serializes their words onto one registered lane. The lane is `a` plus channel tag `sel` plus qualifier `enable`, the same triple `ar_demux14` consumes. A valid/ready handshake on each input and on the output lets the lane be backpressured.

## Interface
- `W`, default 1: data width of each channel and of `a`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  arbitration enable; when low, no new word is granted onto the lane.
- `in_valid`  in  4  per-channel word-present strobe.
- `in_data`  in  4*W  channel i data is at bits [i*W +: W].
- `in_ready`  out  4  per-channel buffer-empty indication.
- `out_ready`  in  1  downstream accepts the current lane word.
- `a`  out  W  serialized data word (registered).
- `sel`  out  2  channel index of `a` (registered).
- `enable`  out  1  lane word valid (registered).

## Operation
- Reset value of every output and state element is 0:
  - `a`, `sel`, `enable`, all buffers empty, arbiter pointer `ptr`.
  - `in_ready` is therefore 4'b1111 during and immediately after reset.
- Per-channel buffer i:
  - `in_ready[i]` = not `buf_full[i]`. It is driven directly from a register, with no combinational path from `out_ready`.
  - Accept: when `in_valid[i]` and `in_ready[i]` are both high at an edge, `buf_data[i]` takes the channel's `in_data` slice and `buf_full[i]` is set.
- Lane load condition `load` = `en` and (any `buf_full`) and (not `enable` or `out_ready`).
- Round-robin grant:
  - The search runs i = `ptr`, `ptr`+1, … modulo 4. The winner `g` is the first i with `buf_full[i]`.
  - On `load`: `a` takes `buf_data[g]`, `sel` takes `g`, `enable` is set, `buf_full[g]` is cleared, and `ptr` takes (`g`+1) mod 4 (2-bit wrap).
- Lane drain: when `enable` and `out_ready` are high and `load` is false, `enable` clears. `a` and `sel` hold their last values.
- Handshake rule: while `enable` is high and `out_ready` is low, `a`, `sel` and `enable` are held stable and no buffer is cleared.
- `en` low:
  - Buffers still accept input.
  - A word already on the lane completes normally.
  - No new grant occurs and `ptr` holds.
- Simultaneous events:
  - A buffer cleared by a grant does not accept new input at the same edge, because `in_ready` was 0. It accepts from the next edge.
  - Output acceptance and a new load at the same edge are a back-to-back transfer, with no bubble.
- Reset mid-operation clears all buffered and lane data immediately. Lost words are not recovered.

## Timing
- Latency: a word accepted into an empty buffer at edge N can appear on the lane (`enable`=1) after edge N+1, provided the lane is free and `en` is high.
- Aggregate throughput is one word per cycle while `out_ready`=1 and several buffers are full.
- A single channel sustains at most one word per 2 cycles, due to the buffer turnaround.
- Fairness: with all four buffers continuously full, grants go 0,1,2,3,0,… No channel waits more than 3 grants.
- All outputs change only on a `clk` edge or on the assertion of `rst`.

## Test plan
- Reset: assert `rst` mid-cycle with traffic present → the following outputs are 0 without waiting for a clock edge:
  - `a`, `sel`, `enable`.
  - `in_ready`=4'b1111.
  - Buffers empty.
- Single channel, W=1, `out_ready`=1, `en`=1:
  - Stimulus: `in_valid`=4'b0010 with `in_data`[1]=1 held for 4 cycles.
  - Required response: `enable` pulses with `a`=1 and `sel`=2'b01 on alternate cycles.
  - `in_ready[1]` toggles 1,0,1,0.
- All four buffers filled in one cycle with data 1,0,1,1 (channels 0..3), then `out_ready`=1:
  - `sel` sequence is 0,1,2,3 on consecutive cycles.
  - `a` sequence is 1,0,1,1.
  - `enable` then falls.
- Pointer wrap: after the last grant was channel 2, load channels 0 and 3 → channel 3 is granted first (`sel`=3), then channel 0.
- Backpressure: `out_ready`=0 for 5 cycles with `enable`=1, `sel`=1 →
  - `a`/`sel`/`enable` are unchanged for all 5 cycles.
  - All other buffers stay full and their `in_ready` stays 0.
  - When `out_ready` returns to 1, the next channel's word loads at that same edge.
- `en`=0 with buffers 0 and 1 full:
  - No lane activity.
  - `ptr` is unchanged.
  - Raising `en` produces `sel`=0 then `sel`=1.
